reco_grad_pipe: RTL and testbench
=================================

# reco_grad_pipe

Multi-lane, pipelined gradient stage for the Axiline recommender training datapath. Each beat carries `LANES` data words. Per lane, the block computes an error term against a bias, then scales and optionally regularises it with fixed-point rate/mu factors and saturates the result. Results go into a small output FIFO with valid/ready handshakes on both sides. The block sits between the dot-product/reduction stage and the weight-update stage and can absorb back-pressure from the update stage without dropping beats.

## Interface
- `BITWIDTH`, 32: signed width of each data lane and each gradient lane.
- `INPUT_BITWIDTH`, 16: signed width of `bias`, `rate`, `mu`.
- `LANES`, 4: number of parallel lanes per beat.
- `FRAC`, 8: fractional bits of `rate`/`mu` (Q format); this is the shift applied after each multiply.
- `DEPTH`, 4: output FIFO depth; a power of two, ≥2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous reset, active-low.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: block accepts a beat this cycle.
- `data_in` in LANES*BITWIDTH: lane i is at bits [i*BITWIDTH +: BITWIDTH], signed.
- `bias` in INPUT_BITWIDTH: signed; shared by all lanes; sampled per accepted beat.
- `rate` in INPUT_BITWIDTH: signed Q.FRAC; sampled per accepted beat.
- `mu` in INPUT_BITWIDTH: signed Q.FRAC; sampled per accepted beat.
- `mode` in 2: 0 = error, 1 = scaled, 2 = scaled + regularised, 3 = zero; sampled per accepted beat.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: consumer takes the head this cycle.
- `grad_out` out LANES*BITWIDTH: FIFO head, with the same lane packing as `data_in`.
- `sat_flag` out 1: sticky; set when any lane of any beat saturated.

## Operation
- A beat is accepted when `in_valid && in_ready`. Transfer on the output side happens when `out_valid && out_ready`.
- Per-lane arithmetic:
  - e = sext(data_in[i]) − sext(bias), computed at BITWIDTH+1 bits.
  - s = (e × rate) >>> FRAC, computed at full product width. The shift is arithmetic (rounds toward −inf).
  - r = (sext(data_in[i]) × mu) >>> FRAC.
- Result per mode:
  - mode 0: e.
  - mode 1: s.
  - mode 2: s + r, summed at one extra bit.
  - mode 3: 0.
- The result saturates to signed BITWIDTH: it clamps to 0x7FF…F or 0x800…0.
- Pipeline:
  - S1 registers the operands plus `mode` on accept, and computes e and both products.
  - S2 shifts, sums, selects and saturates.
  - The FIFO then stores the result.
- Flow control is credit-based. `in_ready = rst && (fifo_count + s1_valid + s2_valid < DEPTH)`.
  - `in_ready` is driven from registers only and never depends on `out_ready`.
  - The pipeline never stalls; every accepted beat reaches the FIFO.
- FIFO behaviour:
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves `fifo_count` unchanged.
  - A pop on the cycle the FIFO becomes non-empty is legal.
  - Ordering is strictly in order.
- `sat_flag` is set on the S2→FIFO write of any beat in which any lane clamped. Only reset clears it.
- Reset (`rst` low at an edge):
  - Clears s1_valid, s2_valid, pointers, `fifo_count` and `sat_flag`.
  - In-flight and buffered beats are discarded.
  - `in_ready` is 0 while `rst` is low.

## Timing
- Reset values: `in_ready` = 0 during reset and 1 on the first cycle after release; `out_valid` = 0; `grad_out` = 0; `sat_flag` = 0.
- Latency: a beat accepted at edge E0 is in S1 after E0, in S2 after E1, and written to the FIFO at E2. `out_valid` is high in the cycle after E2, so minimum latency is 3 cycles.
- Throughput: one beat per cycle while `out_ready` = 1.
- When full (count + in-flight = DEPTH), `in_ready` drops in the same cycle the credit is consumed, i.e. in the cycle after the accepting edge.
- A pop frees a credit: `in_ready` rises in the following cycle.
- `grad_out` is held stable while `out_valid && !out_ready`.
- Reset mid-stream: `out_valid` is 0 from the cycle after the reset edge. No stale beat appears after release.

## Test plan
- Scaled mode: mode=1, bias=500, rate=0x0080 (0.5), lanes {1000, 2000, −500, 0}, single beat → `grad_out` lanes {250, 750, −500, −250}; `out_valid` rises 3 cycles after accept; `sat_flag`=0.
- Error and zero modes: lanes {10, −10, 0, 7}, bias=3.
  - mode 0 → {7, −13, −3, 4}.
  - Next beat with mode 3 → {0, 0, 0, 0}.
  - Results emerge back to back.
- Regularised mode: mode=2, bias=0, rate=0x0100 (1.0), mu=0x0040 (0.25), all lanes 256 → all lanes 320.
- Saturation: mode 1, lane0=0x7FFFFFFF, bias=0xFFFF (−1), rate=0x7FFF → lane0=0x7FFFFFFF, `sat_flag`=1 and it stays 1 through 10 later clean beats. lane1=0x80000000, bias=1, rate=0x7FFF → lane1=0x80000000.
- Back-pressure: `out_ready`=0, 6 beats (lane0 = 1..6, mode 0, bias 0) offered with `in_valid` held → exactly 4 accepted, then `in_ready`=0. Raise `out_ready` → outputs 1..6 in order, with no loss or duplicates; `fifo_count` never exceeds 4.
- Reset mid-operation: 2 beats in the FIFO and 2 in flight; drive `rst`=0 for 2 cycles → `out_valid`=0 and `in_ready`=0 during reset. After release, `in_ready`=1, no output appears until a new beat is sent, and `sat_flag`=0.

Source files
------------

// File: rtl/reco_grad_pipe_if.sv
`timescale 1ns/1ps
// reco_grad_pipe_if
// Bundles the input and output handshakes of reco_grad_pipe.
//   master : the side that offers beats and consumes results (e.g. a testbench)
//   slave  : the gradient stage itself
// Signals:
//   in_valid/in_ready     : input beat handshake
//   data_in               : LANES packed signed words, lane i at [i*BITWIDTH +: BITWIDTH]
//   bias, rate, mu, mode  : per-beat operands, sampled on accept
//   out_valid/out_ready   : output FIFO head handshake
//   grad_out              : FIFO head, same lane packing as data_in
//   sat_flag              : sticky saturation indicator
interface reco_grad_pipe_if #(
  parameter int BITWIDTH       = 32,
  parameter int INPUT_BITWIDTH = 16,
  parameter int LANES          = 4
);
  logic                         in_valid;
  logic                         in_ready;
  logic [LANES*BITWIDTH-1:0]    data_in;
  logic [INPUT_BITWIDTH-1:0]    bias;
  logic [INPUT_BITWIDTH-1:0]    rate;
  logic [INPUT_BITWIDTH-1:0]    mu;
  logic [1:0]                   mode;
  logic                         out_valid;
  logic                         out_ready;
  logic [LANES*BITWIDTH-1:0]    grad_out;
  logic                         sat_flag;

  modport master (
    output in_valid, data_in, bias, rate, mu, mode, out_ready,
    input  in_ready, out_valid, grad_out, sat_flag
  );

  modport slave (
    input  in_valid, data_in, bias, rate, mu, mode, out_ready,
    output in_ready, out_valid, grad_out, sat_flag
  );
endinterface

// File: rtl/reco_grad_pipe.sv
`timescale 1ns/1ps
// reco_grad_pipe
// Multi-lane pipelined gradient stage. Per lane it forms the error against a
// shared bias, optionally scales it by rate and adds a mu-weighted
// regularisation term, saturates to BITWIDTH and queues the beat in a small
// output FIFO. Input acceptance is credit based, so the two compute stages
// never stall and no accepted beat is ever dropped.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous reset, active low
//   bus : reco_grad_pipe_if.slave (input beat, output FIFO head, sat_flag)
module reco_grad_pipe #(
  parameter int BITWIDTH       = 32,
  parameter int INPUT_BITWIDTH = 16,
  parameter int LANES          = 4,
  parameter int FRAC           = 8,
  parameter int DEPTH          = 4
) (
  input logic             clk,
  input logic             rst,
  reco_grad_pipe_if.slave bus
);

  localparam int EW       = BITWIDTH + 1;
  localparam int PW       = EW + INPUT_BITWIDTH;
  localparam int RW       = BITWIDTH + INPUT_BITWIDTH;
  localparam int SW       = PW + 1;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int CREDIT_W = CW + 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-BITWIDTH+1){1'b0}}, {(BITWIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-BITWIDTH+1){1'b1}}, {(BITWIDTH-1){1'b0}}};
  localparam logic [BITWIDTH-1:0]  LANE_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};
  localparam logic [BITWIDTH-1:0]  LANE_MIN = {1'b1, {(BITWIDTH-1){1'b0}}};

  // Stage 1: registered operands and the combinational error/products
  logic                             s1_valid;
  logic signed [BITWIDTH-1:0]       s1_data [LANES];
  logic signed [INPUT_BITWIDTH-1:0] s1_bias;
  logic signed [INPUT_BITWIDTH-1:0] s1_rate;
  logic signed [INPUT_BITWIDTH-1:0] s1_mu;
  logic [1:0]                       s1_mode;
  logic signed [EW-1:0]             s1_e  [LANES];
  logic signed [PW-1:0]             s1_ps [LANES];
  logic signed [RW-1:0]             s1_pr [LANES];

  // Stage 2: registered error/products and the saturated result
  logic                             s2_valid;
  logic [1:0]                       s2_mode;
  logic signed [EW-1:0]             s2_e  [LANES];
  logic signed [PW-1:0]             s2_ps [LANES];
  logic signed [RW-1:0]             s2_pr [LANES];
  logic [LANES*BITWIDTH-1:0]        s2_result;
  logic                             s2_sat;
  logic signed [PW-1:0]             s_sh;
  logic signed [RW-1:0]             r_sh;
  logic signed [SW-1:0]             sel;

  // Output FIFO
  logic [LANES*BITWIDTH-1:0]        fifo_mem [DEPTH];
  logic [AW-1:0]                    wr_ptr;
  logic [AW-1:0]                    rd_ptr;
  logic [CW-1:0]                    fifo_count;
  logic                             sat_flag_q;
  logic                             out_valid;
  logic                             in_ready;
  logic                             accept;
  logic                             push;
  logic                             pop;
  logic [CREDIT_W-1:0]              credits_used;

  // Every beat in S1, S2 or the FIFO holds one credit; as long as the total
  // stays below DEPTH the FIFO can always absorb what is in flight.
  assign credits_used = CREDIT_W'(fifo_count) + CREDIT_W'(s1_valid) + CREDIT_W'(s2_valid);
  assign in_ready     = rst && (credits_used < CREDIT_W'(DEPTH));
  assign accept       = bus.in_valid && in_ready;
  assign push         = s2_valid;
  assign out_valid    = (fifo_count != '0);
  assign pop          = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.grad_out  = out_valid ? fifo_mem[rd_ptr] : '0;
  assign bus.sat_flag  = sat_flag_q;

  // Capture operands of an accepted beat; only the valid bit needs a reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        for (int i = 0; i < LANES; i++) begin
          s1_data[i] <= bus.data_in[i*BITWIDTH +: BITWIDTH];
        end
        s1_bias <= bus.bias;
        s1_rate <= bus.rate;
        s1_mu   <= bus.mu;
        s1_mode <= bus.mode;
      end
    end
  end

  // Error and both full-width products; casts of signed values sign-extend
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      s1_e[i]  = EW'(s1_data[i]) - EW'(s1_bias);
      s1_ps[i] = PW'(s1_e[i]) * PW'(s1_rate);
      s1_pr[i] = RW'(s1_data[i]) * RW'(s1_mu);
    end
  end

  // Advance the beat into S2 unconditionally; the pipeline never stalls
  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_valid <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        for (int i = 0; i < LANES; i++) begin
          s2_e[i]  <= s1_e[i];
          s2_ps[i] <= s1_ps[i];
          s2_pr[i] <= s1_pr[i];
        end
        s2_mode <= s1_mode;
      end
    end
  end

  // Shift (arithmetic, floors toward -inf), select by mode and clamp per lane
  always_comb begin
    s2_result = '0;
    s2_sat    = 1'b0;
    s_sh      = '0;
    r_sh      = '0;
    sel       = '0;
    for (int i = 0; i < LANES; i++) begin
      s_sh = s2_ps[i] >>> FRAC;
      r_sh = s2_pr[i] >>> FRAC;
      case (s2_mode)
        2'd0:    sel = SW'(s2_e[i]);
        2'd1:    sel = SW'(s_sh);
        2'd2:    sel = SW'(s_sh) + SW'(r_sh);
        default: sel = '0;
      endcase
      if (sel > SAT_MAX) begin
        s2_result[i*BITWIDTH +: BITWIDTH] = LANE_MAX;
        s2_sat = 1'b1;
      end else if (sel < SAT_MIN) begin
        s2_result[i*BITWIDTH +: BITWIDTH] = LANE_MIN;
        s2_sat = 1'b1;
      end else begin
        s2_result[i*BITWIDTH +: BITWIDTH] = sel[BITWIDTH-1:0];
      end
    end
  end

  // FIFO pointers wrap naturally because DEPTH is a power of two; credits
  // guarantee a push never lands on a full FIFO
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      sat_flag_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= s2_result;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && s2_sat) begin
        sat_flag_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reco_grad_pipe.sv
`timescale 1ns/1ps
// tb_reco_grad_pipe
// Self-checking bench for reco_grad_pipe: a table of directed single beats,
// hand-written multi-cycle sequences (back-to-back results, back-pressure,
// reset mid-stream) and a randomized phase, all scored against a plain
// integer model of the lane arithmetic.
module tb_reco_grad_pipe;

  localparam int BITWIDTH       = 32;
  localparam int INPUT_BITWIDTH = 16;
  localparam int LANES          = 4;
  localparam int FRAC           = 8;
  localparam int DEPTH          = 4;
  localparam int WIDE           = LANES * BITWIDTH;
  localparam int NVEC           = 7;
  localparam longint SMAX       = 64'sd2147483647;
  localparam longint SMIN       = -64'sd2147483648;

  typedef struct {
    logic [WIDE-1:0] data;
    logic [15:0]     bias;
    logic [15:0]     rate;
    logic [15:0]     mu;
    logic [1:0]      mode;
    logic [WIDE-1:0] expected;
    logic            expSat;
  } vec_t;

  logic            clk;
  logic            rst;
  int              testsRun    = 0;
  int              testsFailed = 0;
  int              popCount    = 0;
  logic [WIDE-1:0] expQ [$];
  logic            expSticky   = 1'b0;
  logic [WIDE:0]   monBeat;
  vec_t            vecs [NVEC];

  reco_grad_pipe_if #(
    .BITWIDTH(BITWIDTH), .INPUT_BITWIDTH(INPUT_BITWIDTH), .LANES(LANES)
  ) bus ();

  reco_grad_pipe #(
    .BITWIDTH(BITWIDTH), .INPUT_BITWIDTH(INPUT_BITWIDTH), .LANES(LANES),
    .FRAC(FRAC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WIDE-1:0] packLanes(input logic [31:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Reference arithmetic in 64-bit integers: returns {sat, lanes}
  function automatic logic [WIDE:0] modelBeat(input logic [WIDE-1:0] d, input logic [15:0] b,
                                              input logic [15:0] r, input logic [15:0] m,
                                              input logic [1:0] md);
    longint   bl, rl, ml, x, e, s, rr, v;
    logic [WIDE-1:0] res;
    logic     sat;
    bl  = longint'($signed(b));
    rl  = longint'($signed(r));
    ml  = longint'($signed(m));
    res = '0;
    sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      x  = longint'($signed(d[i*BITWIDTH +: BITWIDTH]));
      e  = x - bl;
      s  = (e * rl) >>> FRAC;
      rr = (x * ml) >>> FRAC;
      case (md)
        2'd0:    v = e;
        2'd1:    v = s;
        2'd2:    v = s + rr;
        default: v = 0;
      endcase
      if (v > SMAX) begin
        v = SMAX;
        sat = 1'b1;
      end else if (v < SMIN) begin
        v = SMIN;
        sat = 1'b1;
      end
      res[i*BITWIDTH +: BITWIDTH] = v[31:0];
    end
    return {sat, res};
  endfunction

  function automatic logic [31:0] randLane();
    logic [15:0] t;
    t = 16'($urandom());
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return $urandom();
      default: return {{16{t[15]}}, t};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [WIDE-1:0] actual,
                             input logic [WIDE-1:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Offer one beat and hold it until accepted (bounded); returns just after the accepting edge
  task automatic applyStimulus(input logic [WIDE-1:0] d, input logic [15:0] b,
                               input logic [15:0] r, input logic [15:0] m,
                               input logic [1:0] md);
    int waitCycles;
    waitCycles   = 0;
    bus.in_valid = 1'b1;
    bus.data_in  = d;
    bus.bias     = b;
    bus.rate     = r;
    bus.mu       = m;
    bus.mode     = md;
    @(negedge clk);
    while (!bus.in_ready && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("accept_within_budget", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drainAll();
    int n;
    n             = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", WIDE'(expQ.size()), 0);
  endtask

  // Scoreboard: credit check, in-order output check and expected-beat capture
  always @(negedge clk) begin
    if (!rst) begin
      expQ.delete();
      expSticky = 1'b0;
    end else begin
      checkOutput("in_ready_credit", bus.in_ready, (expQ.size() < DEPTH));
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_output: got %h, expected no beat", bus.grad_out);
        end else begin
          checkOutput("scoreboard_grad_out", bus.grad_out, expQ.pop_front());
          popCount++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        monBeat = modelBeat(bus.data_in, bus.bias, bus.rate, bus.mu, bus.mode);
        expQ.push_back(monBeat[WIDE-1:0]);
        expSticky = expSticky | monBeat[WIDE];
      end
    end
  end

  initial begin
    int   nextIdx;
    int   base;
    logic acceptNow;

    vecs[0] = '{packLanes(1000, 2000, -500, 0), 16'd500, 16'h0080, 16'h0000, 2'd1,
                packLanes(250, 750, -500, -250), 1'b0};
    vecs[1] = '{packLanes(10, -10, 0, 7), 16'd3, 16'h0000, 16'h0000, 2'd0,
                packLanes(7, -13, -3, 4), 1'b0};
    vecs[2] = '{packLanes(10, -10, 0, 7), 16'd3, 16'h0000, 16'h0000, 2'd3,
                packLanes(0, 0, 0, 0), 1'b0};
    vecs[3] = '{packLanes(256, 256, 256, 256), 16'd0, 16'h0100, 16'h0040, 2'd2,
                packLanes(320, 320, 320, 320), 1'b0};
    vecs[4] = '{packLanes(-1, 1, 255, -256), 16'd0, 16'h0000, 16'h0001, 2'd2,
                packLanes(-1, 0, 0, -1), 1'b0};
    vecs[5] = '{packLanes(32'h7FFF_FFFF, 0, 0, 0), 16'hFFFF, 16'h7FFF, 16'h0000, 2'd1,
                packLanes(32'h7FFF_FFFF, 127, 127, 127), 1'b1};
    vecs[6] = '{packLanes(0, 32'h8000_0000, 0, 0), 16'd1, 16'h7FFF, 16'h0000, 2'd1,
                packLanes(-128, 32'h8000_0000, -128, -128), 1'b1};

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.bias      = '0;
    bus.rate      = '0;
    bus.mu        = '0;
    bus.mode      = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_grad_out", bus.grad_out, 0);
    checkOutput("reset_sat_flag", bus.sat_flag, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;

    // Directed table: latency, value and sticky flag per beat
    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v].data, vecs[v].bias, vecs[v].rate, vecs[v].mu, vecs[v].mode);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_latency_c1", v), bus.out_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_latency_c2", v), bus.out_valid, 0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_latency_c3", v), bus.out_valid, 1);
      checkOutput($sformatf("vec%0d_grad_out", v), bus.grad_out, vecs[v].expected);
      checkOutput($sformatf("vec%0d_sat_flag", v), bus.sat_flag, vecs[v].expSat);
      @(posedge clk);
      #1;
    end

    // Error then zero mode, results must come out on consecutive cycles
    applyStimulus(packLanes(10, -10, 0, 7), 16'd3, 16'h0000, 16'h0000, 2'd0);
    applyStimulus(packLanes(10, -10, 0, 7), 16'd3, 16'h0000, 16'h0000, 2'd3);
    @(negedge clk);
    checkOutput("b2b_not_yet", bus.out_valid, 0);
    @(negedge clk);
    checkOutput("b2b_first_valid", bus.out_valid, 1);
    checkOutput("b2b_first_value", bus.grad_out, packLanes(7, -13, -3, 4));
    @(negedge clk);
    checkOutput("b2b_second_valid", bus.out_valid, 1);
    checkOutput("b2b_second_value", bus.grad_out, packLanes(0, 0, 0, 0));
    @(posedge clk);
    #1;

    // sat_flag stays set through clean beats
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(packLanes(k, 2 * k, -k, 100), 16'd0, 16'h0100, 16'h0000,
                    2'($urandom_range(0, 1)));
      @(negedge clk);
      checkOutput($sformatf("sat_sticky_%0d", k), bus.sat_flag, 1);
      @(posedge clk);
      #1;
    end
    drainAll();

    // Back-pressure: hold 6 beats against a stalled consumer
    base          = popCount;
    nextIdx       = 1;
    bus.out_ready = 1'b0;
    bus.bias      = '0;
    bus.rate      = '0;
    bus.mu        = '0;
    bus.mode      = 2'd0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = (nextIdx <= 6);
      bus.data_in  = packLanes(nextIdx, 0, 0, 0);
      @(negedge clk);
      acceptNow = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acceptNow) nextIdx++;
    end
    checkOutput("bp_accepted", WIDE'(nextIdx - 1), 4);
    @(negedge clk);
    checkOutput("bp_in_ready_full", bus.in_ready, 0);
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_no_credit_before_pop", bus.in_ready, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_credit_after_pop", bus.in_ready, 1);
    @(posedge clk);
    #1;
    applyStimulus(packLanes(5, 0, 0, 0), 16'd0, 16'h0000, 16'h0000, 2'd0);
    applyStimulus(packLanes(6, 0, 0, 0), 16'd0, 16'h0000, 16'h0000, 2'd0);
    drainAll();
    checkOutput("bp_pop_count", WIDE'(popCount - base), 6);

    // Reset with two beats buffered and two in flight
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(packLanes(100 + k, 0, 0, 0), 16'd0, 16'h0100, 16'h0000, 2'd1);
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready_low", bus.in_ready, 0);
    @(negedge clk);
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_release_in_ready", bus.in_ready, 1);
    checkOutput("midrst_sat_cleared", bus.sat_flag, 0);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("midrst_no_stale_%0d", c), bus.out_valid, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    base = popCount;
    applyStimulus(packLanes(42, -42, 7, 0), 16'd2, 16'h0100, 16'h0000, 2'd0);
    drainAll();
    checkOutput("midrst_new_beat_pop", WIDE'(popCount - base), 1);

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.data_in   = {randLane(), randLane(), randLane(), randLane()};
      bus.bias      = 16'($urandom());
      bus.rate      = 16'($urandom());
      bus.mu        = 16'($urandom());
      bus.mode      = 2'($urandom_range(0, 3));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drainAll();
    checkOutput("random_sat_flag", bus.sat_flag, expSticky);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
